// File: rtl/plu_seq_pkg.sv
// Shared types and default parameters for the PLU operand-load sequencer.
package plu_seq_pkg;

  localparam int DEF_STAGES = 3;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/plu_tok_pipe.sv
// Valid/last token shift register; bit k of o_valid is the write enable for
// pipeline register k+1. i_hold freezes every position.
module plu_tok_pipe
  import plu_seq_pkg::*;
#(
  parameter int STAGES = DEF_STAGES
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_hold,
  input  logic              i_in_valid,
  input  logic              i_in_last,
  output logic [STAGES-1:0] o_valid,
  output logic              o_last_tail
);

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
      r_last  <= '0;
    end else if (!i_hold) begin
      r_valid[0] <= i_in_valid;
      r_last[0]  <= i_in_valid & i_in_last;
      for (int k = 1; k < STAGES; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_last[k]  <= r_last[k-1];
      end
    end
  end

  assign o_valid     = r_valid;
  assign o_last_tail = r_valid[STAGES-1] & r_last[STAGES-1];

endmodule

// File: rtl/plu_seq_ctrl.sv
// PLU sequencer: issues N operand loads and walks each through STAGES write
// enables. Optional freeze input enabled by defining PLU_SEQ_STALL_EN.
module plu_seq_ctrl
  import plu_seq_pkg::*;
#(
  parameter int STAGES = DEF_STAGES,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_count,
  input  logic              i_stall,
  output logic              o_a_we,
  output logic              o_w_we,
  output logic [CNT_W-1:0]  o_issue_idx,
  output logic [STAGES-1:0] o_r_we,
  output logic              o_busy,
  output logic              o_done,
  output state_t            o_state
);

  // Handshake: i_start/i_count form a one-cycle request that is consumed
  // only in IDLE; o_done is a single-cycle pulse with no acknowledge.

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_n;
  logic               w_hold;
  logic               w_issue;
  logic               w_last;
  logic               w_fin;
  logic [STAGES-1:0]  w_valid;
  logic               w_last_tail;

`ifdef PLU_SEQ_STALL_EN
  assign w_hold = i_stall;
`else
  logic w_unused_stall;
  assign w_unused_stall = i_stall;
  assign w_hold         = 1'b0;
`endif

  assign w_last = (r_idx == r_n - CNT_W'(1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_n     <= '0;
    end else begin
      r_state <= w_next_state;
      if (!w_hold) begin
        if (r_state == IDLE && i_start) begin
          r_idx <= '0;
          r_n   <= i_count;
        end else if (r_state == ISSUE && !w_last) begin
          r_idx <= r_idx + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_fin        = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && !w_hold) w_next_state = (i_count == '0) ? DRAIN : ISSUE;
      end
      ISSUE: begin
        w_issue = !w_hold;
        if (!w_hold && w_last) w_next_state = DRAIN;
      end
      DRAIN: begin
        // A zero-length burst has no tokens, so it finishes on its first DRAIN cycle.
        w_fin = !w_hold && (w_last_tail || r_n == '0);
        if (w_fin) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  plu_tok_pipe #(
    .STAGES(STAGES)
  ) u_tok_pipe (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_hold      (w_hold),
    .i_in_valid  (w_issue),
    .i_in_last   (w_last),
    .o_valid     (w_valid),
    .o_last_tail (w_last_tail)
  );

  assign o_a_we      = w_issue;
  assign o_w_we      = w_issue;
  assign o_issue_idx = w_issue ? r_idx : '0;
  assign o_r_we      = w_hold ? '0 : w_valid;
  assign o_done      = w_fin;
  assign o_busy      = (r_state != IDLE);
  assign o_state     = r_state;

endmodule
